// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register. Captures the execute result, store data and
// memory/writeback controls, and tracks an in-flight MULTU so that MFHI,
// MFLO and a second MULTU are interlocked until Hi/Lo hold the product.
module ex_mem_stage #(
    parameter int DATA_W   = 32,
    parameter int MULT_LAT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [5:0]        ex_funct,
    input  logic [1:0]        ex_alu_op,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_rt_data,
    input  logic [4:0]        ex_dest,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              mem_stall,
    input  logic              flush,
    output logic              stall_req,
    output logic              mult_busy,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [4:0]        mem_dest,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write
);

    localparam logic [5:0] MultLatInit = 6'(MULT_LAT);
    localparam logic [5:0] FnMultu     = 6'd25;
    localparam logic [5:0] FnMfhi      = 6'd16;
    localparam logic [5:0] FnMflo      = 6'd18;

    logic [5:0] multCnt;
    logic       rType;
    logic       isMultu;
    logic       isMfhi;
    logic       isMflo;
    logic       hazard;
    logic       accept;

    // Decode the Hi/Lo-sensitive R-type functions and derive the interlock.
    always_comb begin
        rType     = ex_valid & (ex_alu_op == 2'b10);
        isMultu   = rType & (ex_funct == FnMultu);
        isMfhi    = rType & (ex_funct == FnMfhi);
        isMflo    = rType & (ex_funct == FnMflo);
        mult_busy = (multCnt != 6'd0);
        hazard    = mult_busy & (isMultu | isMfhi | isMflo);
        stall_req = hazard | mem_stall;
        accept    = ex_valid & ~hazard & ~mem_stall & ~flush;
    end

    // Pipeline register: reset, flush bubble, stall hold, hazard bubble, load.
    always_ff @(posedge clk) begin
        if (rst || flush || (!mem_stall && (hazard || !ex_valid))) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_dest       <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
        end else if (!mem_stall) begin
            mem_valid      <= 1'b1;
            mem_result     <= ex_result;
            mem_store_data <= ex_rt_data;
            mem_dest       <= ex_dest;
            mem_reg_write  <= ex_reg_write;
            mem_mem_read   <= ex_mem_read;
            mem_mem_write  <= ex_mem_write;
        end
    end

    // MULTU countdown: keeps running through stall and flush once started.
    always_ff @(posedge clk) begin
        if (rst) begin
            multCnt <= 6'd0;
        end else if (accept && isMultu) begin
            multCnt <= MultLatInit;
        end else if (multCnt != 6'd0) begin
            multCnt <= multCnt - 6'd1;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: each scenario pushes the expected MEM
// register contents when it drives EX, and pops/compares after the edge.
module tb_ex_mem_stage;

    typedef logic [72:0] memOut_t; // {valid, result, store, dest, rw, mr, mw}

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [5:0]  ex_funct;
    logic [1:0]  ex_alu_op;
    logic [31:0] ex_result;
    logic [31:0] ex_rt_data;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        mem_stall;
    logic        flush;
    logic        stall_req;
    logic        mult_busy;
    logic        mem_valid;
    logic [31:0] mem_result;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_dest;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;

    memOut_t expQ[$];
    memOut_t exp;
    memOut_t act;
    int      nCmp = 0;
    int      nErr = 0;

    localparam memOut_t Bubble = '0;

    ex_mem_stage #(.DATA_W(32), .MULT_LAT(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_funct(ex_funct), .ex_alu_op(ex_alu_op),
        .ex_result(ex_result), .ex_rt_data(ex_rt_data), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .mem_stall(mem_stall), .flush(flush),
        .stall_req(stall_req), .mult_busy(mult_busy), .mem_valid(mem_valid),
        .mem_result(mem_result), .mem_store_data(mem_store_data),
        .mem_dest(mem_dest), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write)
    );

    always #5 clk = ~clk;

    assign act = {mem_valid, mem_result, mem_store_data, mem_dest,
                  mem_reg_write, mem_mem_read, mem_mem_write};

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] res, input logic [31:0] rt,
                         input logic [4:0] dst, input logic rw, input logic mr,
                         input logic mw);
        ex_valid = v; ex_alu_op = op; ex_funct = fn; ex_result = res;
        ex_rt_data = rt; ex_dest = dst; ex_reg_write = rw;
        ex_mem_read = mr; ex_mem_write = mw;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_stall = 1'b0; flush = 1'b0;
        drive(1'b1, 2'b10, 6'd32, 32'h1234, 32'h5678, 5'd7, 1'b1, 1'b1, 1'b1);
        expQ.push_back(Bubble);
        tick();
        exp = expQ.pop_front(); nCmp++;
        if (act !== exp) begin nErr++; $display("FAIL reset_out: got %h want %h", act, exp); end
        nCmp++;
        if ({stall_req, mult_busy} !== 2'b00) begin
            nErr++; $display("FAIL reset_busy: got %b want 00", {stall_req, mult_busy});
        end
        rst = 1'b0;
        drive(1'b0, 2'b00, 6'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_add();
        drive(1'b1, 2'b10, 6'd32, 32'h7, 32'h11, 5'd5, 1'b1, 1'b0, 1'b0);
        #1; nCmp++;
        if (stall_req !== 1'b0) begin nErr++; $display("FAIL add_stall: got %b want 0", stall_req); end
        expQ.push_back({1'b1, 32'h7, 32'h11, 5'd5, 1'b1, 1'b0, 1'b0});
        tick();
        exp = expQ.pop_front(); nCmp++;
        if (act !== exp) begin nErr++; $display("FAIL add_out: got %h want %h", act, exp); end
    endtask

    task automatic test_multu_mfhi();
        // cycle T: MULTU accepted
        drive(1'b1, 2'b10, 6'd25, 32'h0, 32'h3, 5'd0, 1'b0, 1'b0, 1'b0);
        #1; nCmp++;
        if (stall_req !== 1'b0) begin nErr++; $display("FAIL multu_stall: got %b want 0", stall_req); end
        expQ.push_back({1'b1, 32'h0, 32'h3, 5'd0, 1'b0, 1'b0, 1'b0});
        tick();
        exp = expQ.pop_front(); nCmp++;
        if (act !== exp) begin nErr++; $display("FAIL multu_out: got %h want %h", act, exp); end
        // cycles T+1..T+32: MFHI held in EX, interlocked
        drive(1'b1, 2'b10, 6'd16, 32'hAAAA_5555, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            #1; nCmp++;
            if ({stall_req, mult_busy} !== 2'b11) begin
                nErr++; $display("FAIL mfhi_interlock T+%0d: got %b want 11", k, {stall_req, mult_busy});
            end
            expQ.push_back(Bubble);
            tick();
            exp = expQ.pop_front(); nCmp++;
            if (act !== exp) begin nErr++; $display("FAIL mfhi_bubble T+%0d: got %h want %h", k, act, exp); end
        end
        // cycle T+33: Hi/Lo valid, MFHI accepted
        #1; nCmp++;
        if ({stall_req, mult_busy} !== 2'b00) begin
            nErr++; $display("FAIL mfhi_release: got %b want 00", {stall_req, mult_busy});
        end
        expQ.push_back({1'b1, 32'hAAAA_5555, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0});
        tick();
        exp = expQ.pop_front(); nCmp++;
        if (act !== exp) begin nErr++; $display("FAIL mfhi_out: got %h want %h", act, exp); end
    endtask

    task automatic test_multu_no_stall();
        drive(1'b1, 2'b10, 6'd25, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        expQ.push_back({1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0});
        tick();
        exp = expQ.pop_front(); nCmp++;
        if (act !== exp) begin nErr++; $display("FAIL nostall_multu: got %h want %h", act, exp); end
        // T+1: ADD behind the MULTU
        drive(1'b1, 2'b10, 6'd32, 32'h42, 32'h9, 5'd6, 1'b1, 1'b0, 1'b0);
        #1; nCmp++;
        if ({stall_req, mult_busy} !== 2'b01) begin
            nErr++; $display("FAIL nostall_add: got %b want 01", {stall_req, mult_busy});
        end
        expQ.push_back({1'b1, 32'h42, 32'h9, 5'd6, 1'b1, 1'b0, 1'b0});
        tick();
        exp = expQ.pop_front(); nCmp++;
        if (act !== exp) begin nErr++; $display("FAIL nostall_add_out: got %h want %h", act, exp); end
        // T+2: store whose funct field happens to be 25 but is not R-type
        drive(1'b1, 2'b00, 6'd25, 32'h1000, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1);
        #1; nCmp++;
        if ({stall_req, mult_busy} !== 2'b01) begin
            nErr++; $display("FAIL nostall_sw: got %b want 01", {stall_req, mult_busy});
        end
        expQ.push_back({1'b1, 32'h1000, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1});
        tick();
        exp = expQ.pop_front(); nCmp++;
        if (act !== exp) begin nErr++; $display("FAIL nostall_sw_out: got %h want %h", act, exp); end
        // T+3..T+33: idle; busy must drop exactly at T+33
        drive(1'b0, 2'b10, 6'd16, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 3; k <= 33; k++) begin
            #1; nCmp++;
            if (mult_busy !== (k <= 32)) begin
                nErr++; $display("FAIL nostall_busy T+%0d: got %b want %b", k, mult_busy, (k <= 32));
            end
            expQ.push_back(Bubble);
            tick();
            exp = expQ.pop_front(); nCmp++;
            if (act !== exp) begin nErr++; $display("FAIL nostall_idle T+%0d: got %h want %h", k, act, exp); end
        end
    endtask

    task automatic test_mem_stall();
        drive(1'b1, 2'b00, 6'd0, 32'h100, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
        expQ.push_back({1'b1, 32'h100, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0});
        tick();
        exp = expQ.pop_front(); nCmp++;
        if (act !== exp) begin nErr++; $display("FAIL lw_out: got %h want %h", act, exp); end
        drive(1'b1, 2'b10, 6'd32, 32'h22, 32'h1, 5'd3, 1'b1, 1'b0, 1'b0);
        mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1; nCmp++;
            if (stall_req !== 1'b1) begin nErr++; $display("FAIL hold_stall %0d: got %b want 1", k, stall_req); end
            expQ.push_back({1'b1, 32'h100, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0});
            tick();
            exp = expQ.pop_front(); nCmp++;
            if (act !== exp) begin nErr++; $display("FAIL hold_out %0d: got %h want %h", k, act, exp); end
        end
        mem_stall = 1'b0;
        #1; nCmp++;
        if (stall_req !== 1'b0) begin nErr++; $display("FAIL release_stall: got %b want 0", stall_req); end
        expQ.push_back({1'b1, 32'h22, 32'h1, 5'd3, 1'b1, 1'b0, 1'b0});
        tick();
        exp = expQ.pop_front(); nCmp++;
        if (act !== exp) begin nErr++; $display("FAIL release_out: got %h want %h", act, exp); end
    endtask

    task automatic test_flush();
        drive(1'b1, 2'b10, 6'd25, 32'h77, 32'h88, 5'd2, 1'b1, 1'b1, 1'b1);
        mem_stall = 1'b1; flush = 1'b1;
        #1; nCmp++;
        if (stall_req !== 1'b1) begin nErr++; $display("FAIL flush_stall: got %b want 1", stall_req); end
        expQ.push_back(Bubble);
        tick();
        exp = expQ.pop_front(); nCmp++;
        if (act !== exp) begin nErr++; $display("FAIL flush_out: got %h want %h", act, exp); end
        mem_stall = 1'b0; flush = 1'b0;
        nCmp++;
        if (mult_busy !== 1'b0) begin nErr++; $display("FAIL flush_busy: got %b want 0", mult_busy); end
        // MFLO right after: no MULTU was started, so no interlock
        drive(1'b1, 2'b10, 6'd18, 32'h5A, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0);
        #1; nCmp++;
        if (stall_req !== 1'b0) begin nErr++; $display("FAIL flush_mflo_stall: got %b want 0", stall_req); end
        expQ.push_back({1'b1, 32'h5A, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0});
        tick();
        exp = expQ.pop_front(); nCmp++;
        if (act !== exp) begin nErr++; $display("FAIL flush_mflo_out: got %h want %h", act, exp); end
    endtask

    task automatic test_reset_mid_mult();
        drive(1'b1, 2'b10, 6'd25, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        expQ.push_back({1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0});
        tick();
        exp = expQ.pop_front(); nCmp++;
        if (act !== exp) begin nErr++; $display("FAIL rstmid_multu: got %h want %h", act, exp); end
        drive(1'b0, 2'b00, 6'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            expQ.push_back(Bubble);
            tick();
            exp = expQ.pop_front(); nCmp++;
            if (act !== exp) begin nErr++; $display("FAIL rstmid_idle T+%0d: got %h want %h", k, act, exp); end
        end
        // T+10: reset while an ADD is presented
        nCmp++;
        if (mult_busy !== 1'b1) begin nErr++; $display("FAIL rstmid_prebusy: got %b want 1", mult_busy); end
        rst = 1'b1;
        drive(1'b1, 2'b10, 6'd32, 32'h99, 32'h98, 5'd10, 1'b1, 1'b0, 1'b0);
        expQ.push_back(Bubble);
        tick();
        exp = expQ.pop_front(); nCmp++;
        if (act !== exp) begin nErr++; $display("FAIL rstmid_out: got %h want %h", act, exp); end
        nCmp++;
        if (mult_busy !== 1'b0) begin nErr++; $display("FAIL rstmid_busy: got %b want 0", mult_busy); end
        rst = 1'b0;
        drive(1'b1, 2'b10, 6'd18, 32'h55, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0);
        #1; nCmp++;
        if (stall_req !== 1'b0) begin nErr++; $display("FAIL rstmid_mflo_stall: got %b want 0", stall_req); end
        expQ.push_back({1'b1, 32'h55, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0});
        tick();
        exp = expQ.pop_front(); nCmp++;
        if (act !== exp) begin nErr++; $display("FAIL rstmid_mflo_out: got %h want %h", act, exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [31:0] d;
        logic [4:0]  dst;
        logic [2:0]  c;
        for (int k = 0; k < 8; k++) begin
            r = $urandom; d = $urandom; dst = 5'($urandom_range(31)); c = 3'($urandom_range(7));
            drive(1'b1, 2'b00, 6'($urandom_range(63)), r, d, dst, c[2], c[1], c[0]);
            expQ.push_back({1'b1, r, d, dst, c});
            tick();
            exp = expQ.pop_front(); nCmp++;
            if (act !== exp) begin nErr++; $display("FAIL b2b %0d: got %h want %h", k, act, exp); end
        end
        drive(1'b0, 2'b00, 6'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        nCmp++;
        if (expQ.size() !== 0) begin nErr++; $display("FAIL queue_drain: got %0d want 0", expQ.size()); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_multu_mfhi();
        test_multu_no_stall();
        test_mem_stall();
        test_flush();
        test_reset_mid_mult();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete within bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register between the execute stage (ALU/shifter/MULTU/HiLo result mux) and the memory stage.
- Captures the execute result, store data and memory/writeback controls.
- Tracks the multi-cycle MULTU in flight and interlocks MFHI/MFLO, and a second MULTU, until Hi/Lo are valid.
- Drives a stall request back to IF/ID/EX and honours downstream stall and flush.

Parameters:
- DATA_W, 32, datapath width of result and store data.
- MULT_LAT, 32, cycles from MULTU acceptance until Hi/Lo hold the product. Legal range 1..63.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_funct  in  6  function field presented to the ALU (Signal).
- ex_alu_op  in  2  ALU op class; 2'b10 = R-type.
- ex_result  in  DATA_W  execute result (ALU/Hi/Lo/shift mux output).
- ex_rt_data  in  DATA_W  rt operand, used as store data.
- ex_dest  in  5  destination register number.
- ex_reg_write  in  1  instruction writes the register file.
- ex_mem_read  in  1  instruction is a load.
- ex_mem_write  in  1  instruction is a store.
- mem_stall  in  1  MEM stage cannot accept; hold register.
- flush  in  1  squash the EX instruction and the register contents.
- stall_req  out  1  freeze PC, IF/ID and ID/EX this cycle.
- mult_busy  out  1  MULTU in flight; Hi/Lo not yet valid.
- mem_valid  out  1  register holds a real instruction.
- mem_result  out  DATA_W  registered ex_result.
- mem_store_data  out  DATA_W  registered ex_rt_data.
- mem_dest  out  5  registered ex_dest.
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered controls, forced 0 when mem_valid=0.

Behaviour:
- Decode (combinational), all gated by ex_valid and ex_alu_op==2'b10:
  - is_multu: funct 25.
  - is_mfhi: funct 16.
  - is_mflo: funct 18.
- hazard = mult_busy & (is_multu | is_mfhi | is_mflo).
- stall_req = hazard | mem_stall. This is combinational, same cycle.
- accept = ex_valid & ~hazard & ~mem_stall & ~flush.
- Register update priority at each edge:
  1. rst: all mem_* outputs = 0, counter = 0.
  2. flush: load a bubble (all mem_* = 0).
  3. mem_stall: hold all mem_* unchanged.
  4. hazard or ~ex_valid: load a bubble.
  5. otherwise: load ex_* fields, mem_valid = 1, controls = ex_* values.
- Bubbles zero every data and control field, not only mem_valid.
- Latency: one cycle from accept to mem_* outputs.
- MULTU counter, 6 bits:
  - Reset value 0.
  - On accept & is_multu: load MULT_LAT.
  - Else if nonzero: decrement by 1 every cycle, regardless of mem_stall or flush.
  - mult_busy = (counter != 0).
- Flush does not cancel a MULTU already accepted; its counter keeps running.
- A flushed MULTU is never accepted and never loads the counter.
- Counter reaches 0 on the cycle the product is written to Hi/Lo. MFHI/MFLO are accepted starting the first cycle mult_busy=0.
- Non-MULTU instructions, including loads, stores and ALU ops, never stall on mult_busy.
- Reset mid-multiply: counter cleared, mult_busy=0 the next cycle.
- No X propagation: every output is defined from the first cycle after reset.

Test Plan:
- Reset, then ADD (alu_op=10, funct=32, result 0x0000_0007, dest 5, reg_write=1) -> next cycle mem_valid=1, mem_result=0x7, mem_dest=5, mem_reg_write=1, stall_req=0.
- MULTU accepted at cycle T -> mult_busy=1 for cycles T+1..T+32 and 0 at T+33. MFHI presented at T+1 -> stall_req=1 and bubbles (mem_valid=0) through T+32. MFHI loads at the T+33 edge and appears at T+34.
- MULTU followed immediately by an ADD and a store (mem_write=1, rt_data 0xDEAD_BEEF) -> no stall. mem_store_data=0xDEAD_BEEF, mem_mem_write=1, counter unaffected.
- Load in the register with mem_stall held high 3 cycles while a new ADD waits -> mem_* outputs unchanged for 3 cycles, stall_req=1. The ADD loads on the first edge after mem_stall drops.
- flush asserted together with mem_stall and a valid MULTU in EX -> mem_valid=0, all controls 0, counter stays 0, mult_busy=0.
- MULTU accepted, then rst asserted at T+10 -> next cycle counter=0, mult_busy=0, all mem_* outputs 0. A following MFLO is accepted without stall.
